fifo_ctrl_fsm: RTL and testbench
================================

Name: fifo_ctrl_fsm

Overview:
Main control state machine for the 4-lane FIFO/arbiter datapath (transmit FIFOs P0..P3 -> weighted arbiter -> receive FIFOs).
- Sequences the datapath through reset, configuration, idle, active and error states.
- Latches and distributes almost-full/almost-empty thresholds to all FIFOs.
- Gates the arbiter enable.
- Captures sticky FIFO error sources.

Parameters:
N_FIFO, 4, lanes per stage; status vectors are 2*N_FIFO wide (tx lanes [N_FIFO-1:0], rx lanes above).
TH_W, 3, threshold width in bits.
DEF_AF, 6, almost-full threshold driven out of reset.
DEF_AE, 1, almost-empty threshold driven out of reset.
IDLE_HOLD, 4, consecutive all-empty cycles required to drop from ACTIVE to IDLE (range 1..15).

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
init  in  1  configuration request; level-sensitive
umbral_af_in  in  TH_W  almost-full threshold requested
umbral_ae_in  in  TH_W  almost-empty threshold requested
fifo_empty  in  2*N_FIFO  empty flags of all FIFOs
fifo_error  in  2*N_FIFO  per-FIFO error pulse (push-when-full / pop-when-empty)
umbral_af_out  out  TH_W  registered almost-full threshold to FIFOs
umbral_ae_out  out  TH_W  registered almost-empty threshold to FIFOs
arb_en  out  1  arbiter enable
idle_out  out  1  high in IDLE
error_out  out  1  high in ERROR
cfg_err  out  1  sticky: last configuration rejected
error_src  out  2*N_FIFO  sticky OR of fifo_error bits seen
state_out  out  3  current state encoding

Behaviour:
- Reset (async, immediate):
  - state=RESET; arb_en, idle_out, error_out, cfg_err, error_src = 0.
  - umbral_af_out=DEF_AF, umbral_ae_out=DEF_AE; idle counter=0.
- State encodings: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Values 5-7 are illegal; decode them as RESET.
- Output decode: Moore outputs, decoded from the state register, so they are valid in the same cycle as state_out.
  - arb_en = (state==ACTIVE); idle_out = (state==IDLE); error_out = (state==ERROR).
- RESET: go to INIT the first clock after reset deasserts, unconditionally.
- INIT:
  - On entry, clear error_src and cfg_err.
  - While init=1, sample umbral_*_in into umbral_*_out every cycle.
  - When init=0, check the held thresholds. The config is valid iff umbral_ae_out < umbral_af_out and umbral_ae_out != 0.
  - Valid -> IDLE. Invalid -> ERROR with cfg_err=1.
  - fifo_error is ignored in INIT.
- IDLE:
  - Priority: |fifo_error -> ERROR; else init -> INIT; else any fifo_empty bit 0 -> ACTIVE; else stay.
  - Arbiter is disabled while in IDLE.
- ACTIVE:
  - Priority: |fifo_error -> ERROR; else init -> INIT.
  - Otherwise the idle counter increments on each cycle with &fifo_empty and resets to 0 on any non-empty cycle.
  - When the counter reaches IDLE_HOLD-1 with all FIFOs still empty -> IDLE. Minimum ACTIVE->IDLE latency is IDLE_HOLD cycles of all-empty.
  - Counter clears on every state exit.
- ERROR:
  - On the transition into ERROR, error_src |= fifo_error. Further fifo_error pulses while in ERROR also OR into error_src.
  - Stay until init=1 -> INIT. Reset also exits ERROR.
- Thresholds change only in INIT and are stable in all other states.
- Simultaneous fifo_error and init in IDLE/ACTIVE: ERROR wins; error_src captures the bits.
- Reset mid-operation (any state): returns to RESET in the same instant; thresholds revert to defaults.

Optional Feature:
FIFO_CTRL_ERR_CNT_EN
- Defined: adds output err_count [7:0], a saturating count (stops at 255) of transitions into ERROR, including cfg_err entries. It is cleared only by reset, not by INIT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_ctrl_pkg: state encoding constants (ST_RESET..ST_ERROR), DEF_AF/DEF_AE defaults, TH_W.
- One sub-module, idle_hold_cnt:
  - Ports: clk, reset, clear, all_empty, done.
  - 4-bit counter; asserts done at IDLE_HOLD-1 with all_empty.
- The FSM and sticky registers stay in the top module.

Test Plan:
- Reset then init=1 for 3 cycles with af=5, ae=2, then init=0:
  - state goes RESET->INIT->IDLE; umbral_af_out=5, umbral_ae_out=2; idle_out=1 the cycle after init falls.
- Config af=2, ae=3 then init=0:
  - ERROR next cycle; cfg_err=1, error_out=1, arb_en=0.
  - A later init=1 returns to INIT and clears cfg_err.
- From IDLE, fifo_empty=8'hFE:
  - ACTIVE next cycle, arb_en=1.
  - After fifo_empty=8'hFF held for 4 cycles (IDLE_HOLD=4): IDLE. A one-cycle non-empty blip restarts the count.
- In ACTIVE, fifo_error=8'h20 pulse together with init=1:
  - ERROR next cycle, error_src=8'h20.
  - A second pulse of 8'h01 in ERROR gives error_src=8'h21.
  - init -> INIT clears error_src to 0.
- Assert reset asynchronously mid-ACTIVE after a config of af=4, ae=1:
  - Without waiting for a clock edge: state_out=0, arb_en=0, umbral_af_out=6, umbral_ae_out=1.
- With FIFO_CTRL_ERR_CNT_EN: force 3 ERROR entries with INIT recoveries between them:
  - err_count=3 and it is not cleared by INIT; reset clears it to 0.

Source files
------------

// File: rtl/fifo_ctrl_fsm_pkg.sv
// Shared constants for the FIFO/arbiter control FSM: state encoding and reset thresholds.
package fifo_ctrl_pkg;

  localparam int N_FIFO    = 4;
  localparam int TH_W      = 3;
  localparam int DEF_AF    = 6;
  localparam int DEF_AE    = 1;
  localparam int IDLE_HOLD = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_ctrl_fsm_if.sv
// Control/status bundle between the datapath FIFOs and the control FSM.
// err_count exists only when FIFO_CTRL_ERR_CNT_EN is defined.
interface fifo_ctrl_fsm_if #(
  parameter int N_FIFO = 4,
  parameter int TH_W   = 3
);

  logic                  init;
  logic [TH_W-1:0]       umbral_af_in;
  logic [TH_W-1:0]       umbral_ae_in;
  logic [2*N_FIFO-1:0]   fifo_empty;
  logic [2*N_FIFO-1:0]   fifo_error;
  logic [TH_W-1:0]       umbral_af_out;
  logic [TH_W-1:0]       umbral_ae_out;
  logic                  arb_en;
  logic                  idle_out;
  logic                  error_out;
  logic                  cfg_err;
  logic [2*N_FIFO-1:0]   error_src;
  logic [2:0]            state_out;
`ifdef FIFO_CTRL_ERR_CNT_EN
  logic [7:0]            err_count;
`endif

  modport master (
`ifdef FIFO_CTRL_ERR_CNT_EN
    input  err_count,
`endif
    output init, umbral_af_in, umbral_ae_in, fifo_empty, fifo_error,
    input  umbral_af_out, umbral_ae_out, arb_en, idle_out, error_out,
           cfg_err, error_src, state_out
  );

  modport slave (
`ifdef FIFO_CTRL_ERR_CNT_EN
    output err_count,
`endif
    input  init, umbral_af_in, umbral_ae_in, fifo_empty, fifo_error,
    output umbral_af_out, umbral_ae_out, arb_en, idle_out, error_out,
           cfg_err, error_src, state_out
  );

endinterface

// File: rtl/fifo_ctrl_fsm_idle_hold_cnt.sv
// Counts consecutive all-empty cycles in ACTIVE; done marks the last cycle before dropping to IDLE.
module idle_hold_cnt
  import fifo_ctrl_pkg::*;
#(
  parameter int IDLE_HOLD = fifo_ctrl_pkg::IDLE_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic all_empty,
  output logic done
);

  localparam logic [3:0] W_LAST = 4'(IDLE_HOLD - 1);

  logic [3:0] r_cnt;

  assign done = all_empty && (r_cnt == W_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || !all_empty || done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// Main control FSM for the 4-lane FIFO/arbiter datapath: thresholds, arbiter gating, sticky errors.
// Optional saturating ERROR-entry counter enabled by FIFO_CTRL_ERR_CNT_EN.
module fifo_ctrl_fsm
  import fifo_ctrl_pkg::*;
#(
  parameter int N_FIFO    = fifo_ctrl_pkg::N_FIFO,
  parameter int TH_W      = fifo_ctrl_pkg::TH_W,
  parameter int DEF_AF    = fifo_ctrl_pkg::DEF_AF,
  parameter int DEF_AE    = fifo_ctrl_pkg::DEF_AE,
  parameter int IDLE_HOLD = fifo_ctrl_pkg::IDLE_HOLD
) (
  input  logic            clk,
  input  logic            reset,
  fifo_ctrl_fsm_if.slave  bus
);

  localparam logic [TH_W-1:0] W_DEF_AF = TH_W'(DEF_AF);
  localparam logic [TH_W-1:0] W_DEF_AE = TH_W'(DEF_AE);

  state_t              r_state;
  state_t              w_next;
  logic [TH_W-1:0]     r_af;
  logic [TH_W-1:0]     r_ae;
  logic                r_cfgErr;
  logic [2*N_FIFO-1:0] r_errSrc;
  logic [2*N_FIFO-1:0] w_errBits;
  logic                w_allEmpty;
  logic                w_anyErr;
  logic                w_cfgOk;
  logic                w_holdDone;
  logic                w_holdClear;
  logic                w_enterInit;
  logic                w_enterError;
  logic                w_captureErr;

  assign w_errBits    = bus.fifo_error;
  assign w_allEmpty   = &bus.fifo_empty;
  assign w_anyErr     = |w_errBits;
  assign w_cfgOk      = (r_ae < r_af) && (r_ae != '0);
  assign w_holdClear  = (r_state != ST_ACTIVE) || (w_next != ST_ACTIVE);
  assign w_enterInit  = (w_next == ST_INIT) && (r_state != ST_INIT);
  assign w_enterError = (w_next == ST_ERROR) && (r_state != ST_ERROR);
  assign w_captureErr = (r_state == ST_IDLE) || (r_state == ST_ACTIVE) || (r_state == ST_ERROR);

  idle_hold_cnt #(.IDLE_HOLD(IDLE_HOLD)) u_idle_hold (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_holdClear),
    .all_empty (w_allEmpty),
    .done      (w_holdDone)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // fifo_error outranks init in IDLE/ACTIVE; illegal encodings behave like RESET
  always_comb begin
    w_next        = r_state;
    bus.arb_en    = 1'b0;
    bus.idle_out  = 1'b0;
    bus.error_out = 1'b0;
    case (r_state)
      ST_RESET: w_next = ST_INIT;
      ST_INIT: begin
        if (!bus.init) w_next = w_cfgOk ? ST_IDLE : ST_ERROR;
      end
      ST_IDLE: begin
        bus.idle_out = 1'b1;
        if (w_anyErr)         w_next = ST_ERROR;
        else if (bus.init)    w_next = ST_INIT;
        else if (!w_allEmpty) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        bus.arb_en = 1'b1;
        if (w_anyErr)        w_next = ST_ERROR;
        else if (bus.init)   w_next = ST_INIT;
        else if (w_holdDone) w_next = ST_IDLE;
      end
      ST_ERROR: begin
        bus.error_out = 1'b1;
        if (bus.init) w_next = ST_INIT;
      end
      default: w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_af <= W_DEF_AF;
      r_ae <= W_DEF_AE;
    end else if ((r_state == ST_INIT) && bus.init) begin
      r_af <= bus.umbral_af_in;
      r_ae <= bus.umbral_ae_in;
    end
  end

  // Entering INIT wipes the sticky flags; fifo_error is not captured while configuring
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfgErr <= 1'b0;
      r_errSrc <= '0;
    end else if (w_enterInit) begin
      r_cfgErr <= 1'b0;
      r_errSrc <= '0;
    end else begin
      if ((r_state == ST_INIT) && (w_next == ST_ERROR)) r_cfgErr <= 1'b1;
      if (w_captureErr) r_errSrc <= r_errSrc | w_errBits;
    end
  end

`ifdef FIFO_CTRL_ERR_CNT_EN
  logic [7:0] r_errCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errCnt <= '0;
    end else if (w_enterError && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign bus.err_count = r_errCnt;
`endif

  assign bus.umbral_af_out = r_af;
  assign bus.umbral_ae_out = r_ae;
  assign bus.cfg_err       = r_cfgErr;
  assign bus.error_src     = r_errSrc;
  assign bus.state_out     = r_state;

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Self-checking bench for fifo_ctrl_fsm: directed vector table, async-reset sequences, random run vs. model.
module tb_fifo_ctrl_fsm;

  localparam int HOLD = 4;

  typedef struct {
    logic       init;
    logic [2:0] af;
    logic [2:0] ae;
    logic [7:0] empty;
    logic [7:0] err;
    int         expState;
    logic [2:0] expAf;
    logic [2:0] expAe;
    logic       expCfg;
    logic [7:0] expSrc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int         mState;
  logic [2:0] mAf;
  logic [2:0] mAe;
  logic       mCfgErr;
  logic [7:0] mErrSrc;
  int         mEmptyStreak;
  int         mErrCnt;

  vec_t vecs[24];

  fifo_ctrl_fsm_if #(.N_FIFO(4), .TH_W(3)) bus ();

  fifo_ctrl_fsm #(
    .N_FIFO(4), .TH_W(3), .DEF_AF(6), .DEF_AE(1), .IDLE_HOLD(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic init, logic [2:0] af, logic [2:0] ae, logic [7:0] empty,
                              logic [7:0] err, int expState, logic [2:0] expAf,
                              logic [2:0] expAe, logic expCfg, logic [7:0] expSrc);
    vec_t v;
    v.init = init; v.af = af; v.ae = ae; v.empty = empty; v.err = err;
    v.expState = expState; v.expAf = expAf; v.expAe = expAe;
    v.expCfg = expCfg; v.expSrc = expSrc;
    return v;
  endfunction

  task automatic modelReset();
    mState = 0; mAf = 3'd6; mAe = 3'd1; mCfgErr = 1'b0;
    mErrSrc = '0; mEmptyStreak = 0; mErrCnt = 0;
  endtask

  // Reference: mode names 0..4 = RESET, INIT, IDLE, ACTIVE, ERROR, advanced once per clock
  task automatic modelStep(input logic init, input logic [2:0] af, input logic [2:0] ae,
                           input logic [7:0] empty, input logic [7:0] err);
    int prev = mState;
    int nxt = mState;
    bit badCfg = 0;
    bit allEmpty = (empty == 8'hFF);
    case (prev)
      0: nxt = 1;
      1: if (!init) begin
           if (mAe < mAf && mAe != 0) nxt = 2;
           else begin nxt = 4; badCfg = 1; end
         end
      2: if (err != 0) nxt = 4; else if (init) nxt = 1; else if (!allEmpty) nxt = 3;
      3: if (err != 0) nxt = 4; else if (init) nxt = 1;
         else if (allEmpty && mEmptyStreak + 1 >= HOLD) nxt = 2;
      4: if (init) nxt = 1;
      default: nxt = 1;
    endcase
    mEmptyStreak = (prev == 3 && nxt == 3 && allEmpty) ? mEmptyStreak + 1 : 0;
    if (prev == 1 && init) begin mAf = af; mAe = ae; end
    if (nxt == 4 && prev != 4 && mErrCnt < 255) mErrCnt++;
    if (nxt == 1 && prev != 1) begin
      mCfgErr = 1'b0; mErrSrc = '0;
    end else begin
      if (badCfg) mCfgErr = 1'b1;
      if (prev >= 2) mErrSrc = mErrSrc | err;
    end
    mState = nxt;
  endtask

  task automatic applyStimulus(input logic init, input logic [2:0] af, input logic [2:0] ae,
                               input logic [7:0] empty, input logic [7:0] err);
    bus.init = init; bus.umbral_af_in = af; bus.umbral_ae_in = ae;
    bus.fifo_empty = empty; bus.fifo_error = err;
    modelStep(init, af, ae, empty, err);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input int st);
    checkOutput({tag, " state"}, 32'(bus.state_out), 32'(st));
    checkOutput({tag, " arb_en"}, 32'(bus.arb_en), 32'(st == 3));
    checkOutput({tag, " idle"}, 32'(bus.idle_out), 32'(st == 2));
    checkOutput({tag, " error_out"}, 32'(bus.error_out), 32'(st == 4));
  endtask

  task automatic checkAgainstModel(input string tag);
    checkState(tag, mState);
    checkOutput({tag, " af"}, 32'(bus.umbral_af_out), 32'(mAf));
    checkOutput({tag, " ae"}, 32'(bus.umbral_ae_out), 32'(mAe));
    checkOutput({tag, " cfg_err"}, 32'(bus.cfg_err), 32'(mCfgErr));
    checkOutput({tag, " error_src"}, 32'(bus.error_src), 32'(mErrSrc));
`ifdef FIFO_CTRL_ERR_CNT_EN
    checkOutput({tag, " err_count"}, 32'(bus.err_count), 32'(mErrCnt));
`endif
  endtask

  task automatic asyncReset(input string tag);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkState(tag, 0);
    checkOutput({tag, " af default"}, 32'(bus.umbral_af_out), 32'd6);
    checkOutput({tag, " ae default"}, 32'(bus.umbral_ae_out), 32'd1);
    checkOutput({tag, " cfg_err"}, 32'(bus.cfg_err), 32'd0);
    checkOutput({tag, " error_src"}, 32'(bus.error_src), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 5, 2, 8'hFF, 8'h00, 1, 6, 1, 0, 8'h00);
    vecs[1]  = mk(1, 5, 2, 8'hFF, 8'h00, 1, 5, 2, 0, 8'h00);
    vecs[2]  = mk(1, 5, 2, 8'hFF, 8'h00, 1, 5, 2, 0, 8'h00);
    vecs[3]  = mk(0, 5, 2, 8'hFF, 8'h00, 2, 5, 2, 0, 8'h00);
    vecs[4]  = mk(0, 0, 0, 8'hFE, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[5]  = mk(0, 0, 0, 8'hFF, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[6]  = mk(0, 0, 0, 8'hFF, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[7]  = mk(0, 0, 0, 8'hFE, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[8]  = mk(0, 0, 0, 8'hFF, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[9]  = mk(0, 0, 0, 8'hFF, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[10] = mk(0, 0, 0, 8'hFF, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[11] = mk(0, 0, 0, 8'hFF, 8'h00, 2, 5, 2, 0, 8'h00);
    vecs[12] = mk(0, 0, 0, 8'hFE, 8'h00, 3, 5, 2, 0, 8'h00);
    vecs[13] = mk(1, 0, 0, 8'hFF, 8'h20, 4, 5, 2, 0, 8'h20);
    vecs[14] = mk(0, 0, 0, 8'hFF, 8'h01, 4, 5, 2, 0, 8'h21);
    vecs[15] = mk(0, 0, 0, 8'hFF, 8'h00, 4, 5, 2, 0, 8'h21);
    vecs[16] = mk(1, 2, 3, 8'hFF, 8'h00, 1, 5, 2, 0, 8'h00);
    vecs[17] = mk(1, 2, 3, 8'hFF, 8'h80, 1, 2, 3, 0, 8'h00);
    vecs[18] = mk(0, 2, 3, 8'hFF, 8'h00, 4, 2, 3, 1, 8'h00);
    vecs[19] = mk(0, 2, 3, 8'hFF, 8'h00, 4, 2, 3, 1, 8'h00);
    vecs[20] = mk(1, 4, 1, 8'hFF, 8'h00, 1, 2, 3, 0, 8'h00);
    vecs[21] = mk(1, 4, 1, 8'hFF, 8'h00, 1, 4, 1, 0, 8'h00);
    vecs[22] = mk(0, 4, 1, 8'hFF, 8'h00, 2, 4, 1, 0, 8'h00);
    vecs[23] = mk(0, 4, 1, 8'hFE, 8'h00, 3, 4, 1, 0, 8'h00);

    bus.init = 1'b0; bus.umbral_af_in = '0; bus.umbral_ae_in = '0;
    bus.fifo_empty = 8'hFF; bus.fifo_error = '0;
    modelReset();
    #12;
    checkState("reset", 0);
    checkOutput("reset af", 32'(bus.umbral_af_out), 32'd6);
    checkOutput("reset ae", 32'(bus.umbral_ae_out), 32'd1);
    checkOutput("reset cfg_err", 32'(bus.cfg_err), 32'd0);
    checkOutput("reset error_src", 32'(bus.error_src), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].init, vecs[i].af, vecs[i].ae, vecs[i].empty, vecs[i].err);
      checkState(tag, vecs[i].expState);
      checkOutput({tag, " af"}, 32'(bus.umbral_af_out), 32'(vecs[i].expAf));
      checkOutput({tag, " ae"}, 32'(bus.umbral_ae_out), 32'(vecs[i].expAe));
      checkOutput({tag, " cfg_err"}, 32'(bus.cfg_err), 32'(vecs[i].expCfg));
      checkOutput({tag, " error_src"}, 32'(bus.error_src), 32'(vecs[i].expSrc));
    end

    // Reset lands mid-ACTIVE after the af=4/ae=1 configuration
    asyncReset("midActive reset");

`ifdef FIFO_CTRL_ERR_CNT_EN
    applyStimulus(1, 2, 3, 8'hFF, 8'h00);
    applyStimulus(1, 2, 3, 8'hFF, 8'h00);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 2, 3, 8'hFF, 8'h00);
      checkOutput($sformatf("errcnt entry%0d state", k), 32'(bus.state_out), 32'd4);
      applyStimulus(1, 2, 3, 8'hFF, 8'h00);
    end
    checkOutput("errcnt after init", 32'(bus.err_count), 32'd3);
    asyncReset("errcnt reset");
    checkOutput("errcnt cleared", 32'(bus.err_count), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic       rInit;
      logic [7:0] rEmpty;
      logic [7:0] rErr;
      rInit  = ($urandom_range(0, 15) == 0);
      rEmpty = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
      rErr   = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      applyStimulus(rInit, 3'($urandom), 3'($urandom), rEmpty, rErr);
      checkAgainstModel($sformatf("rand%0d", i));
      if (i == 1500) asyncReset("rand reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
